// File: rtl/addsub_pkg.sv
// Shared constants and FSM encoding for the shared add/subtract datapath.
package addsub_pkg;

  localparam int WORD_W = 32;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/addsub_core.sv
// Purely combinational 32-bit add/subtract with carry-out and signed overflow.
module addsub_core
  import addsub_pkg::*;
(
  input  logic signed [WORD_W-1:0] a,
  input  logic signed [WORD_W-1:0] b,
  input  logic                     sub,
  output logic signed [WORD_W-1:0] sum,
  output logic                     cout,
  output logic                     ovf
);

  logic signed [WORD_W-1:0] b_eff;
  logic                     cin;
  logic        [WORD_W:0]   full;

  always_comb begin
    b_eff = (sub == OP_SUB) ? ~b : b;
    cin   = (sub == OP_ADD) ? 1'b0 : 1'b1;
    full  = {1'b0, a} + {1'b0, b_eff} + {{WORD_W{1'b0}}, cin};
    sum   = full[WORD_W-1:0];
    cout  = full[WORD_W];
    ovf   = (a[WORD_W-1] == b_eff[WORD_W-1]) && (sum[WORD_W-1] != a[WORD_W-1]);
  end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one add/subtract datapath among NREQ requesters,
// holding operands for SETTLE cycles before capturing a tagged response.
module addsub_arbiter
  import addsub_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int IDW    = 2,
  parameter int SETTLE = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_sub,
  input  logic [NREQ*WORD_W-1:0] req_a,
  input  logic [NREQ*WORD_W-1:0] req_b,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [IDW-1:0]         resp_id,
  output logic [WORD_W-1:0]      resp_sum,
  output logic                   resp_cout,
  output logic                   resp_ovf,
  output logic                   busy
);

  localparam int CNT_W = 4;

  state_t                   state, state_nxt;
  logic [IDW-1:0]           rr_ptr;
  logic [IDW-1:0]           winner;
  logic                     found;
  logic                     accept;
  logic                     resp_fire;
  logic [CNT_W-1:0]         cnt;

  logic signed [WORD_W-1:0] a_p0;
  logic signed [WORD_W-1:0] b_p0;
  logic                     sub_p0;
  logic [IDW-1:0]           id_p0;

  logic signed [WORD_W-1:0] sum_c;
  logic                     cout_c;
  logic                     ovf_c;

  // Returns {found, index}: first valid requester after ptr, wrapping at NREQ-1.
  function automatic logic [IDW:0] pick_winner(input logic [NREQ-1:0] valid,
                                               input logic [IDW-1:0]  ptr);
    logic [IDW:0] res;
    int           idx;
    res = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (valid[idx]) res = {1'b1, idx[IDW-1:0]};
    end
    return res;
  endfunction

  always_comb begin
    {found, winner} = pick_winner(req_valid, rr_ptr);
    accept          = (state == IDLE) && found && !rst;
    resp_fire       = (state == DONE) && resp_valid && resp_ready;
    busy            = (state != IDLE) && !rst;
    req_ready       = '0;
    if (accept) req_ready[winner] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (cnt == '0) state_nxt = DONE;
      DONE:    if (resp_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: operands captured at acceptance, held through the settle window
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0   <= req_a[winner*WORD_W +: WORD_W];
      b_p0   <= req_b[winner*WORD_W +: WORD_W];
      sub_p0 <= req_sub[winner];
      id_p0  <= winner;
    end
  end

  addsub_core u_core (
    .a    (a_p0),
    .b    (b_p0),
    .sub  (sub_p0),
    .sum  (sum_c),
    .cout (cout_c),
    .ovf  (ovf_c)
  );

  // Stage p1: settled result registered onto the response channel
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rr_ptr     <= IDW'(NREQ - 1);
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_sum   <= '0;
      resp_cout  <= 1'b0;
      resp_ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        rr_ptr <= winner;
        cnt    <= CNT_W'(SETTLE - 1);
      end else if (state == BUSY && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (state == BUSY && cnt == '0) begin
        resp_valid <= 1'b1;
        resp_id    <= id_p0;
        resp_sum   <= sum_c;
        resp_cout  <= cout_c;
        resp_ovf   <= ovf_c;
      end else if (resp_fire) begin
        resp_valid <= 1'b0;
      end
    end
  end

  assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));

endmodule

// File: tb/tb_addsub_arbiter.sv
// Scoreboard bench for addsub_arbiter: stimulus pushes expected responses, a monitor pops on handshake.
module tb_addsub_arbiter;

  localparam int NREQ   = 4;
  localparam int IDW    = 2;
  localparam int SETTLE = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ-1:0]    req_sub;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic               resp_valid;
  logic               resp_ready;
  logic [IDW-1:0]     resp_id;
  logic [31:0]        resp_sum;
  logic               resp_cout;
  logic               resp_ovf;
  logic               busy;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [31:0]    sum;
    logic           cout;
    logic           ovf;
  } exp_t;

  exp_t exp_q[$];
  int   grant_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  addsub_arbiter #(.NREQ(NREQ), .IDW(IDW), .SETTLE(SETTLE)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_sub    (req_sub),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_sum   (resp_sum),
    .resp_cout  (resp_cout),
    .resp_ovf   (resp_ovf),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting on DUT", name);
  endtask

  function automatic exp_t mk(input int id, input logic [31:0] sum, input logic cout, input logic ovf);
    exp_t e;
    e.id   = IDW'(id);
    e.sum  = sum;
    e.cout = cout;
    e.ovf  = ovf;
    return e;
  endfunction

  // Monitor: ready sanity every cycle, grant log, response compare on handshake
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      check("ready_in_reset", 64'(req_ready), 64'd0);
    end else begin
      check("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
      for (int i = 0; i < NREQ; i++)
        if (req_valid[i] && req_ready[i]) grant_q.push_back(i);
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL resp_unexpected: got id %0d sum 0x%0h, expected no response", resp_id, resp_sum);
        end else begin
          e = exp_q.pop_front();
          check("resp_id",   64'(resp_id),   64'(e.id));
          check("resp_sum",  64'(resp_sum),  64'(e.sum));
          check("resp_cout", 64'(resp_cout), 64'(e.cout));
          check("resp_ovf",  64'(resp_ovf),  64'(e.ovf));
        end
      end
    end
  end

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while (!(exp_q.size() == 0 && !busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) timeout("drain");
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst       = 1'b1;
    req_valid = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Single request from an idle DUT: expects same-cycle ready and SETTLE-cycle latency
  task automatic issue(input int id, input logic sub, input logic [31:0] a, input logic [31:0] b,
                       input exp_t e);
    int n = 0;
    int lat = 0;
    @(posedge clk);
    #1;
    req_sub[id]         = sub;
    req_a[id*32 +: 32]  = a;
    req_b[id*32 +: 32]  = b;
    req_valid[id]       = 1'b1;
    @(negedge clk);
    check("ready_same_cycle", 64'(req_ready[id]), 64'd1);
    while (!req_ready[id] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[id]) begin
      timeout("grant_wait");
      req_valid[id] = 1'b0;
      return;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    req_valid[id] = 1'b0;
    while (!resp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", 64'(lat), 64'(SETTLE));
    drain();
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [35:0] snap;
    int          n;
    int          order[5] = '{0, 1, 2, 3, 0};

    rst        = 1'b1;
    req_valid  = 4'b0001;
    req_sub    = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    req_valid = '0;
    rst       = 1'b0;
    @(negedge clk);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_sum",   64'(resp_sum),   64'd0);
    check("rst_resp_id",    64'(resp_id),    64'd0);
    check("rst_resp_flags", 64'({resp_cout, resp_ovf}), 64'd0);
    check("rst_busy",       64'(busy),       64'd0);

    issue(0, 1'b0, 32'h0000_0005, 32'h0000_0003, mk(0, 32'h0000_0008, 1'b0, 1'b0));
    issue(1, 1'b1, 32'h0000_0003, 32'h0000_0005, mk(1, 32'hFFFF_FFFE, 1'b0, 1'b0));
    issue(2, 1'b1, 32'h8000_0000, 32'h0000_0001, mk(2, 32'h7FFF_FFFF, 1'b1, 1'b1));
    issue(3, 1'b0, 32'hFFFF_FFFF, 32'h0000_0001, mk(3, 32'h0000_0000, 1'b1, 1'b0));
    issue(0, 1'b0, 32'h7FFF_FFFF, 32'h0000_0001, mk(0, 32'h8000_0000, 1'b0, 1'b1));
    issue(1, 1'b1, 32'h0000_0005, 32'h0000_0005, mk(1, 32'h0000_0000, 1'b1, 1'b0));

    // Round-robin with all requesters holding valid
    do_reset();
    req_sub = 4'b1100;
    req_a   = {32'h0000_0001, 32'h0000_0030, 32'h0000_0020, 32'h0000_0010};
    req_b   = {32'h0000_0002, 32'h0000_0003, 32'h0000_0002, 32'h0000_0001};
    exp_q.push_back(mk(0, 32'h0000_0011, 1'b0, 1'b0));
    exp_q.push_back(mk(1, 32'h0000_0022, 1'b0, 1'b0));
    exp_q.push_back(mk(2, 32'h0000_002D, 1'b1, 1'b0));
    exp_q.push_back(mk(3, 32'hFFFF_FFFF, 1'b0, 1'b0));
    exp_q.push_back(mk(0, 32'h0000_0011, 1'b0, 1'b0));
    grant_q.delete();
    req_valid = 4'b1111;
    n = 0;
    @(negedge clk);
    while (grant_q.size() < 5 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (grant_q.size() < 5) timeout("rr_grants");
    @(posedge clk);
    #1;
    req_valid = '0;
    drain();
    check("rr_grant_count", 64'(grant_q.size()), 64'd5);
    for (int k = 0; k < 5 && k < grant_q.size(); k++)
      check("rr_grant_order", 64'(grant_q[k]), 64'(order[k]));

    // Backpressure: response held, pending request not granted
    @(posedge clk);
    #1;
    resp_ready       = 1'b0;
    req_sub          = '0;
    req_a[1*32 +: 32] = 32'h0000_1234;
    req_b[1*32 +: 32] = 32'h0000_1111;
    req_a[2*32 +: 32] = 32'h0000_0002;
    req_b[2*32 +: 32] = 32'h0000_0002;
    req_valid[1]     = 1'b1;
    exp_q.push_back(mk(1, 32'h0000_2345, 1'b0, 1'b0));
    exp_q.push_back(mk(2, 32'h0000_0004, 1'b0, 1'b0));
    n = 0;
    @(negedge clk);
    while (!req_ready[1] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[1]) timeout("bp_grant1");
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    req_valid[2] = 1'b1;
    n = 0;
    @(negedge clk);
    while (!resp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!resp_valid) timeout("bp_resp");
    snap = {resp_id, resp_sum, resp_cout, resp_ovf};
    repeat (5) begin
      @(negedge clk);
      check("bp_valid_held", 64'(resp_valid), 64'd1);
      check("bp_resp_stable", 64'({resp_id, resp_sum, resp_cout, resp_ovf}), 64'(snap));
      check("bp_no_grant", 64'(req_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    @(negedge clk);
    check("bp_no_same_cycle_grant", 64'(req_ready), 64'd0);
    n = 0;
    while (!req_ready[2] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[2]) timeout("bp_grant2");
    @(posedge clk);
    #1;
    req_valid[2] = 1'b0;
    drain();

    // Reset while BUSY: result discarded, requester 0 first after reset
    @(posedge clk);
    #1;
    req_sub[2]        = 1'b1;
    req_a[2*32 +: 32] = 32'h0000_0009;
    req_b[2*32 +: 32] = 32'h0000_0004;
    req_valid[2]      = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready[2] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready[2]) timeout("rst_busy_grant");
    @(posedge clk);
    #1;
    check("rst_busy_busy", 64'(busy), 64'd1);
    rst               = 1'b1;
    req_sub           = '0;
    req_a[0 +: 32]    = 32'h0000_0040;
    req_b[0 +: 32]    = 32'h0000_0002;
    req_a[3*32 +: 32] = 32'h0000_0007;
    req_b[3*32 +: 32] = 32'h0000_0001;
    req_valid         = 4'b1001;
    @(negedge clk);
    check("rst_busy_ready_low", 64'(req_ready), 64'd0);
    check("rst_busy_busy_low",  64'(busy),      64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", 64'(resp_valid), 64'd0);
    check("post_rst_idle",  64'(busy),       64'd0);
    check("post_rst_grant0", 64'(req_ready), 64'b0001);
    exp_q.push_back(mk(0, 32'h0000_0042, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    req_valid = '0;
    drain();
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
